// File: rtl/delta_compress_unit.sv
// Purpose : streaming word compressor emitting LITERAL / DELTA / RUN tokens with a byte-length tag.
// Latency : the token for an accepted word is valid on the next cycle; runs emit nothing until closed.
// Backpr. : one registered output slot; in_ready drops while the slot is held or a split DELTA is pending.
module delta_compress_unit #(
   parameter int DATA_W = 32,
   parameter int RUN_W  = 8
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            enable,
   input  logic                            mode,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_W-1:0]               in_data,
   input  logic                            in_last,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_W-1:0]               out_data,
   output logic [1:0]                      out_status,
   output logic [$clog2(DATA_W/8):0]       out_nbytes,
   output logic                            out_last
);

   localparam int NBYTES = DATA_W / 8;
   localparam int NB_W   = $clog2(DATA_W/8) + 1;

   localparam logic [1:0] ST_NONE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_DELTA = 2'b10;
   localparam logic [1:0] ST_LIT   = 2'b11;

   localparam logic [RUN_W:0]    RUN_MAX   = {1'b0, {RUN_W{1'b1}}};
   localparam logic [NB_W-1:0]   NB_LIT    = NB_W'(NBYTES);
   localparam logic [NB_W-1:0]   NB_RUN    = NB_W'((RUN_W + 7) / 8);

   typedef enum logic [1:0] {
      S_FIRST  = 2'd0,
      S_STREAM = 2'd1,
      S_PEND   = 2'd2
   } state_t;

   state_t              state_q,      state_d;
   logic                blk_mode_q,   blk_mode_d;
   logic [DATA_W-1:0]   prev_q,       prev_d;
   logic [RUN_W-1:0]    run_cnt_q,    run_cnt_d;
   logic [DATA_W-1:0]   pend_delta_q, pend_delta_d;
   logic                pend_last_q,  pend_last_d;
   logic                out_valid_q,  out_valid_d;
   logic [DATA_W-1:0]   out_data_q,   out_data_d;
   logic [1:0]          out_status_q, out_status_d;
   logic [NB_W-1:0]     out_nbytes_q, out_nbytes_d;
   logic                out_last_q,   out_last_d;

   logic                slot_free;
   logic                accept;
   logic [DATA_W-1:0]   delta;
   logic [RUN_W:0]      run_p1;

   // Smallest byte count whose sign extension reproduces the full delta.
   function automatic logic [NB_W-1:0] delta_nbytes(input logic [DATA_W-1:0] d);
      logic [NB_W-1:0] nb;
      logic            found;
      logic            fits;
      nb    = NB_LIT;
      found = 1'b0;
      for (int k = 1; k < NBYTES; k++) begin
         fits = 1'b1;
         for (int b = 8*k; b < DATA_W; b++) begin
            if (d[b] != d[8*k-1]) fits = 1'b0;
         end
         if (fits && !found) begin
            nb    = NB_W'(k);
            found = 1'b1;
         end
      end
      return nb;
   endfunction

   assign slot_free  = !out_valid_q || out_ready;
   assign in_ready   = enable && (state_q != S_PEND) && slot_free;
   assign accept     = in_valid && in_ready;
   assign delta      = in_data - prev_q;
   assign run_p1     = {1'b0, run_cnt_q} + 1'b1;

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_status = out_status_q;
   assign out_nbytes = out_nbytes_q;
   assign out_last   = out_last_q;

   // Next-state, token selection and output slot management.
   always_comb begin
      logic              emit;
      logic [DATA_W-1:0] tok_data;
      logic [1:0]        tok_status;
      logic [NB_W-1:0]   tok_nbytes;
      logic              tok_last;

      state_d      = state_q;
      blk_mode_d   = blk_mode_q;
      prev_d       = prev_q;
      run_cnt_d    = run_cnt_q;
      pend_delta_d = pend_delta_q;
      pend_last_d  = pend_last_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_status_d = out_status_q;
      out_nbytes_d = out_nbytes_q;
      out_last_d   = out_last_q;
      emit         = 1'b0;
      tok_data     = '0;
      tok_status   = ST_NONE;
      tok_nbytes   = '0;
      tok_last     = 1'b0;

      // A consumed token empties the slot; idle slot shows all-zero fields.
      if (out_valid_q && out_ready) begin
         out_valid_d  = 1'b0;
         out_data_d   = '0;
         out_status_d = ST_NONE;
         out_nbytes_d = '0;
         out_last_d   = 1'b0;
      end

      if (enable) begin
         unique case (state_q)
            S_FIRST: begin
               if (accept) begin
                  blk_mode_d = mode;
                  prev_d     = in_data;
                  emit       = 1'b1;
                  tok_data   = in_data;
                  tok_status = ST_LIT;
                  tok_nbytes = NB_LIT;
                  tok_last   = in_last;
                  state_d    = S_STREAM;
               end
            end
            S_STREAM: begin
               if (accept) begin
                  if (!blk_mode_q) begin
                     emit       = 1'b1;
                     tok_data   = in_data;
                     tok_status = ST_LIT;
                     tok_nbytes = NB_LIT;
                     tok_last   = in_last;
                  end else begin
                     prev_d = in_data;
                     if (delta == '0) begin
                        if (in_last) begin
                           emit       = 1'b1;
                           tok_data   = DATA_W'(run_p1);
                           tok_status = ST_RUN;
                           tok_nbytes = NB_RUN;
                           tok_last   = 1'b1;
                        end else if (run_p1 == RUN_MAX) begin
                           emit       = 1'b1;
                           tok_data   = DATA_W'(RUN_MAX);
                           tok_status = ST_RUN;
                           tok_nbytes = NB_RUN;
                           run_cnt_d  = '0;
                        end else begin
                           run_cnt_d = run_p1[RUN_W-1:0];
                        end
                     end else if (run_cnt_q == '0) begin
                        emit       = 1'b1;
                        tok_data   = delta;
                        tok_status = ST_DELTA;
                        tok_nbytes = delta_nbytes(delta);
                        tok_last   = in_last;
                     end else begin
                        // Close the run first; the delta follows from PEND.
                        emit         = 1'b1;
                        tok_data     = DATA_W'(run_cnt_q);
                        tok_status   = ST_RUN;
                        tok_nbytes   = NB_RUN;
                        run_cnt_d    = '0;
                        pend_delta_d = delta;
                        pend_last_d  = in_last;
                        state_d      = S_PEND;
                     end
                  end
               end
            end
            S_PEND: begin
               if (slot_free) begin
                  emit       = 1'b1;
                  tok_data   = pend_delta_q;
                  tok_status = ST_DELTA;
                  tok_nbytes = delta_nbytes(pend_delta_q);
                  tok_last   = pend_last_q;
                  state_d    = S_STREAM;
               end
            end
            default: state_d = S_FIRST;
         endcase
      end

      if (emit) begin
         out_valid_d  = 1'b1;
         out_data_d   = tok_data;
         out_status_d = tok_status;
         out_nbytes_d = tok_nbytes;
         out_last_d   = tok_last;
         if (tok_last) begin
            state_d   = S_FIRST;
            prev_d    = '0;
            run_cnt_d = '0;
         end
      end
   end

   // State and output slot registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_FIRST;
         blk_mode_q   <= 1'b0;
         prev_q       <= '0;
         run_cnt_q    <= '0;
         pend_delta_q <= '0;
         pend_last_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_status_q <= ST_NONE;
         out_nbytes_q <= '0;
         out_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         blk_mode_q   <= blk_mode_d;
         prev_q       <= prev_d;
         run_cnt_q    <= run_cnt_d;
         pend_delta_q <= pend_delta_d;
         pend_last_q  <= pend_last_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_status_q <= out_status_d;
         out_nbytes_q <= out_nbytes_d;
         out_last_q   <= out_last_d;
      end
   end

endmodule

// File: tb/tb_delta_compress_unit.sv
// Purpose : directed bench for delta_compress_unit with a token scoreboard.
// Latency : expected tokens are queued as words are driven and checked as they are consumed.
// Backpr. : out_ready is held low for a stretch to exercise the stalled output slot.
module tb_delta_compress_unit;

   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_DELTA = 2'b10;
   localparam logic [1:0] ST_LIT   = 2'b11;

   logic        clk;
   logic        resetn;
   logic        enable;
   logic        mode;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_status;
   logic [2:0]  out_nbytes;
   logic        out_last;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  st;
      logic [2:0]  nb;
      logic        last;
   } tok_t;

   tok_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   tok_idx     = 0;

   delta_compress_unit #(.DATA_W(32), .RUN_W(8)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .enable     (enable),
      .mode       (mode),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_status (out_status),
      .out_nbytes (out_nbytes),
      .out_last   (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [1:0] st, input logic [2:0] nb,
                       input logic l);
      tok_t t;
      t.data = d;
      t.st   = st;
      t.nb   = nb;
      t.last = l;
      exp_q.push_back(t);
   endtask

   // Drive one word and hold it until accepted; returns 1 time unit after the accepting edge.
   task automatic send(input logic [31:0] d, input logic l);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      assert (n < 200) else begin
         miscompares++;
         $error("FAIL accept_timeout observed=%0d expected=<200", n);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Scoreboard: compare every token at the cycle it is consumed.
   always @(negedge clk) begin
      if (resetn) begin
         if (out_valid && out_ready) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
               miscompares++;
               $error("FAIL unexpected_token observed=%h expected=none", out_data);
            end
            if (exp_q.size() != 0) begin
               tok_t e;
               e = exp_q.pop_front();
               chk($sformatf("tok%0d_data", tok_idx),   out_data,          e.data);
               chk($sformatf("tok%0d_status", tok_idx), 32'(out_status),   32'(e.st));
               chk($sformatf("tok%0d_nbytes", tok_idx), 32'(out_nbytes),   32'(e.nb));
               chk($sformatf("tok%0d_last", tok_idx),   32'(out_last),     32'(e.last));
            end
            tok_idx++;
         end else if (!out_valid) begin
            chk("idle_status", 32'(out_status), 32'd0);
         end
      end
   end

   initial begin
      int n;
      resetn    = 1'b0;
      enable    = 1'b1;
      mode      = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid",  32'(out_valid),  32'd0);
      chk("rst_out_data",   out_data,        32'd0);
      chk("rst_out_status", 32'(out_status), 32'd0);
      chk("rst_out_nbytes", 32'(out_nbytes), 32'd0);
      chk("rst_out_last",   32'(out_last),   32'd0);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // T1: deltas; mode change mid-block must be ignored
      push(32'd2,   ST_LIT,   3'd4, 1'b0);
      push(32'd99,  ST_DELTA, 3'd1, 1'b0);
      push(32'd900, ST_DELTA, 3'd2, 1'b1);
      send(32'd2, 1'b0);
      mode = 1'b0;
      send(32'd101, 1'b0);
      send(32'd1001, 1'b1);
      mode = 1'b1;

      // T2: run then split delta; in_ready low for exactly the PEND cycle
      push(32'd5, ST_LIT,   3'd4, 1'b0);
      push(32'd3, ST_RUN,   3'd1, 1'b0);
      push(32'd2, ST_DELTA, 3'd1, 1'b1);
      send(32'd5, 1'b0);
      send(32'd5, 1'b0);
      send(32'd5, 1'b0);
      send(32'd5, 1'b0);
      send(32'd7, 1'b1);
      chk("t2_pend_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("t2_after_pend_in_ready", 32'(in_ready), 32'd1);

      // T5: output stall mid-T2
      push(32'd5, ST_LIT,   3'd4, 1'b0);
      push(32'd3, ST_RUN,   3'd1, 1'b0);
      push(32'd2, ST_DELTA, 3'd1, 1'b1);
      send(32'd5, 1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t5_stall_valid",    32'(out_valid),  32'd1);
         chk("t5_stall_data",     out_data,        32'd5);
         chk("t5_stall_status",   32'(out_status), 32'(ST_LIT));
         chk("t5_stall_in_ready", 32'(in_ready),   32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(32'd5, 1'b0);
      send(32'd5, 1'b0);
      send(32'd5, 1'b0);
      send(32'd7, 1'b1);

      // T3: run saturation
      push(32'd1,   ST_LIT, 3'd4, 1'b0);
      push(32'd255, ST_RUN, 3'd1, 1'b0);
      push(32'd1,   ST_RUN, 3'd1, 1'b1);
      send(32'd1, 1'b0);
      for (int i = 0; i < 255; i++) send(32'd1, 1'b0);
      send(32'd1, 1'b1);

      // T4: wrap-around and sign-extended byte counts
      push(32'hFFFF_FFFF, ST_LIT,   3'd4, 1'b0);
      push(32'h0000_0001, ST_DELTA, 3'd1, 1'b0);
      push(32'h0000_0010, ST_DELTA, 3'd1, 1'b0);
      push(32'hFFFF_FFF0, ST_DELTA, 3'd1, 1'b0);
      push(32'h0000_0080, ST_DELTA, 3'd2, 1'b1);
      send(32'hFFFF_FFFF, 1'b0);
      send(32'h0000_0000, 1'b0);
      send(32'h0000_0010, 1'b0);
      send(32'h0000_0000, 1'b0);
      send(32'h0000_0080, 1'b1);

      // T6a: literal pass-through, repeated words stay literal
      mode = 1'b0;
      push(32'd7, ST_LIT, 3'd4, 1'b0);
      push(32'd7, ST_LIT, 3'd4, 1'b0);
      push(32'd9, ST_LIT, 3'd4, 1'b1);
      send(32'd7, 1'b0);
      send(32'd7, 1'b0);
      send(32'd9, 1'b1);
      mode = 1'b1;

      // T6b: reset in the middle of a run
      push(32'd4, ST_LIT, 3'd4, 1'b0);
      send(32'd4, 1'b0);
      send(32'd4, 1'b0);
      send(32'd4, 1'b0);
      resetn = 1'b0;
      #2;
      chk("t6_rst_out_valid",  32'(out_valid),  32'd0);
      chk("t6_rst_out_data",   out_data,        32'd0);
      chk("t6_rst_out_status", 32'(out_status), 32'd0);
      chk("t6_rst_out_nbytes", 32'(out_nbytes), 32'd0);
      chk("t6_rst_out_last",   32'(out_last),   32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      push(32'd4, ST_LIT, 3'd4, 1'b1);
      send(32'd4, 1'b1);

      // T6c: enable low freezes the input side and the pending run
      push(32'd20, ST_LIT,   3'd4, 1'b0);
      push(32'd1,  ST_RUN,   3'd1, 1'b0);
      push(32'd10, ST_DELTA, 3'd1, 1'b1);
      send(32'd20, 1'b0);
      send(32'd20, 1'b0);
      in_valid = 1'b1;
      in_data  = 32'd30;
      in_last  = 1'b1;
      enable   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t6_dis_in_ready",  32'(in_ready),  32'd0);
         chk("t6_dis_out_valid", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      enable = 1'b1;
      send(32'd30, 1'b1);

      // Drain the scoreboard
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
